// File: rtl/rnn_pkg.sv
// rnn_pkg: shared Q4.12 fixed-point types, constants and the dot-product FSM states
package rnn_pkg;
   typedef logic signed [15:0] fx16_t;
   localparam int FRAC_BITS = 12;
   localparam fx16_t FX_MAX = 16'h7FFF;
   localparam fx16_t FX_MIN = 16'h8000;
   localparam fx16_t FX_ONE = 16'h1000;
   typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINISH, HOLD} state_t;
endpackage

// File: rtl/fx_round_sat.sv
// fx_round_sat: rounds a wide Q.24 value half-up to Q4.12 and saturates to 16 bits
module fx_round_sat import rnn_pkg::*; #(
   parameter int ACC_W = 40
) (
   input  logic signed [ACC_W-1:0] acc,
   output fx16_t                   q
);
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (FRAC_BITS - 1));
   localparam logic signed [ACC_W-1:0] HI = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(-32768);
   logic signed [ACC_W-1:0] r;
   always_comb begin
      r = (acc + HALF) >>> FRAC_BITS;
      q = r > HI ? FX_MAX : r < LO ? FX_MIN : fx16_t'(r[15:0]);
   end
endmodule

// File: rtl/dot_accumulator.sv
// dot_accumulator: streams N_TERMS Q4.12 w/x pairs, accumulates their products plus
// a bias, and hands a rounded, saturated Q4.12 pre-activation downstream.
module dot_accumulator import rnn_pkg::*; #(
   parameter int N_TERMS = 16,
   parameter int ACC_W   = 40
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  start,
   input  fx16_t bias,
   input  logic  in_valid,
   output logic  in_ready,
   input  fx16_t w,
   input  fx16_t x,
   output logic  out_valid,
   input  logic  out_ready,
   output fx16_t out,
   output logic  busy
);
   localparam int CW = $clog2(N_TERMS + 1);
   state_t                  state;
   logic [CW-1:0]           cnt;
   logic signed [31:0]      prod;
   logic                    prod_v;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   fx16_t                   bias_q;
   fx16_t                   rounded;
   logic                    accept;
   assign accept = in_valid && in_ready;
   // bias is Q4.12, aligned to the Q8.24 accumulator before rounding
   assign sum = acc + (ACC_W'(bias_q) <<< FRAC_BITS);
   fx_round_sat #(.ACC_W(ACC_W)) u_round_sat (.acc(sum), .q(rounded));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         prod      <= '0;
         prod_v    <= 1'b0;
         acc       <= '0;
         bias_q    <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         prod_v <= accept;
         if (accept) prod <= 32'(w) * 32'(x);
         if (prod_v) acc <= acc + ACC_W'(prod);
         case (state)
            IDLE: if (start) begin
               state    <= ACCUM;
               bias_q   <= bias;
               acc      <= '0;
               cnt      <= '0;
               in_ready <= 1'b1;
               busy     <= 1'b1;
            end
            ACCUM: if (accept) begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N_TERMS - 1)) begin
                  state    <= DRAIN;
                  in_ready <= 1'b0;
               end
            end
            DRAIN: state <= FINISH;
            FINISH: begin
               out       <= rounded;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
